// File: rtl/alu128_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu128_seq_pkg
// Purpose  : Shared types and constants for the 128-bit ALU stream sequencer.
//            Holds the sequencer state encoding, the ALU flag struct and
//            default widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu128_seq_pkg;

    localparam int OP_W_DEF   = 128;
    localparam int BEAT_W_DEF = 32;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EXEC    = 2'd1,
        SEND    = 2'd2
    } seq_state_t;

    // Bit order matches the ALU flag bus {c,z,o,s}, c in bit 3.
    typedef struct packed {
        logic c;
        logic z;
        logic o;
        logic s;
    } alu_flags_t;

    // Counter width for a modulo-n counter; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu128_beat_counter.sv
`default_nettype none
// ============================================================================
// Module   : alu128_beat_counter
// Purpose  : Modulo-N beat counter with increment, synchronous clear and
//            terminal-count flag.
// Ports    : clk, rst (async, active-high)
//            inc   - advance by one, wrapping to 0 after N-1
//            clr   - synchronous return to 0 (wins over inc)
//            count - current value
//            tc    - high while count == N-1
// Revision : 1.0 - initial release
// ============================================================================
module alu128_beat_counter
    import alu128_seq_pkg::*;
#(
    parameter  int N  = 8,
    localparam int CW = cnt_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          tc
);

    localparam logic [CW-1:0] c_last_count = CW'(N - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= (r_count == c_last_count) ? '0 : r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign tc    = (r_count == c_last_count);

endmodule
`default_nettype wire

// File: rtl/alu128_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu128_stream_sequencer
// Purpose  : Host-side sequencer for the 128-bit combinational ALU. Collects
//            2*BEATS input beats (op1 then op2, LSW first), holds them on the
//            ALU inputs for one EXEC cycle, captures result and flags, then
//            streams the result back out LSW first.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready/in_data/in_opsel/in_mode - operand stream
//            alu_op1/alu_op2/alu_opsel/alu_mode        - to ALU
//            alu_result/alu_flags                      - from ALU
//            out_valid/out_ready/out_data/out_last/out_flags - result stream
//            sticky_clr/sticky_flags - only with ALU128_SEQ_STICKY_EN
// Config   : `define ALU128_SEQ_STICKY_EN adds sticky {c,o} flag accumulation.
// Revision : 1.0 - initial release
// ============================================================================
module alu128_stream_sequencer
    import alu128_seq_pkg::*;
#(
    parameter int OP_W   = OP_W_DEF,
    parameter int BEAT_W = BEAT_W_DEF   // OP_W must be a multiple of BEAT_W
) (
`ifdef ALU128_SEQ_STICKY_EN
    input  logic              sticky_clr,
    output logic [1:0]        sticky_flags,
`endif
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BEAT_W-1:0] in_data,
    input  logic [2:0]        in_opsel,
    input  logic              in_mode,
    output logic [OP_W-1:0]   alu_op1,
    output logic [OP_W-1:0]   alu_op2,
    output logic [2:0]        alu_opsel,
    output logic              alu_mode,
    input  logic [OP_W-1:0]   alu_result,
    input  logic [3:0]        alu_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic              out_last,
    output logic [3:0]        out_flags
);

    localparam int BEATS  = OP_W / BEAT_W;
    localparam int IN_N   = 2 * BEATS;
    localparam int IN_CW  = cnt_width(IN_N);
    localparam int OUT_CW = cnt_width(BEATS);

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    logic              w_exec;
    logic              w_in_fire;
    logic              w_out_fire;
    logic [IN_CW-1:0]  w_in_cnt;
    logic              w_in_tc;
    logic [OUT_CW-1:0] w_out_cnt;
    logic              w_out_tc;

    logic [OP_W-1:0]   r_op1;
    logic [OP_W-1:0]   r_op2;
    logic [2:0]        r_opsel;
    logic              r_mode;
    logic [OP_W-1:0]   r_result;
    alu_flags_t        r_flags;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // Input counter spans both operands; its wrap coincides with EXEC entry.
    alu128_beat_counter #(.N(IN_N)) u_in_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_in_fire),
        .clr   (1'b0),
        .count (w_in_cnt),
        .tc    (w_in_tc)
    );

    alu128_beat_counter #(.N(BEATS)) u_out_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_out_fire),
        .clr   (1'b0),
        .count (w_out_cnt),
        .tc    (w_out_tc)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            COLLECT: if (w_in_fire && w_in_tc)   w_next_state = EXEC;
            EXEC:                                w_next_state = SEND;
            SEND:    if (w_out_fire && w_out_tc) w_next_state = COLLECT;
            default:                             w_next_state = COLLECT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // in_ready is held low while reset is asserted so no beat is seen as
    // accepted before the sequencer is running.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_exec    = 1'b0;
        case (r_state)
            COLLECT: in_ready  = ~rst;
            EXEC:    w_exec    = 1'b1;
            SEND:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // ---------------- operand / sideband capture ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op1   <= '0;
            r_op2   <= '0;
            r_opsel <= '0;
            r_mode  <= 1'b0;
        end else if (w_in_fire) begin
            for (int k = 0; k < BEATS; k++) begin
                if (w_in_cnt == IN_CW'(k))
                    r_op1[k*BEAT_W +: BEAT_W] <= in_data;
                if (w_in_cnt == IN_CW'(k + BEATS))
                    r_op2[k*BEAT_W +: BEAT_W] <= in_data;
            end
            // Sideband is a per-frame attribute: only beat 0 carries it.
            if (w_in_cnt == '0) begin
                r_opsel <= in_opsel;
                r_mode  <= in_mode;
            end
        end
    end

    // ---------------- result capture ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_exec) begin
            r_result <= alu_result;
            r_flags  <= alu_flags;
        end
    end

`ifdef ALU128_SEQ_STICKY_EN
    alu_flags_t w_flags_in;
    logic [1:0] r_sticky;

    assign w_flags_in = alu_flags;

    // A clear coinciding with a capture drops older history but keeps the
    // flags of the frame being captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 2'b00;
        end else if (w_exec) begin
            r_sticky <= (sticky_clr ? 2'b00 : r_sticky) | {w_flags_in.c, w_flags_in.o};
        end else if (sticky_clr) begin
            r_sticky <= 2'b00;
        end
    end

    assign sticky_flags = r_sticky;
`endif

    // ---------------- output word select ----------------
    always_comb begin
        out_data = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (w_out_cnt == OUT_CW'(k))
                out_data = r_result[k*BEAT_W +: BEAT_W];
        end
    end

    assign out_last  = out_valid & w_out_tc;
    assign out_flags = r_flags;
    assign alu_op1   = r_op1;
    assign alu_op2   = r_op2;
    assign alu_opsel = r_opsel;
    assign alu_mode  = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_alu128_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu128_stream_sequencer
// Purpose  : Self-checking bench for alu128_stream_sequencer with an adder
//            ALU stub (result = op1+op2, flags {carry, zero, 0, sign}).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu128_stream_sequencer;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [2:0]   in_opsel;
    logic         in_mode;
    logic [127:0] alu_op1;
    logic [127:0] alu_op2;
    logic [2:0]   alu_opsel;
    logic         alu_mode;
    logic [127:0] alu_result;
    logic [3:0]   alu_flags;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic [3:0]   out_flags;
`ifdef ALU128_SEQ_STICKY_EN
    logic         sticky_clr;
    logic [1:0]   sticky_flags;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    alu128_stream_sequencer dut (
`ifdef ALU128_SEQ_STICKY_EN
        .sticky_clr   (sticky_clr),
        .sticky_flags (sticky_flags),
`endif
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_opsel   (in_opsel),
        .in_mode    (in_mode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_opsel  (alu_opsel),
        .alu_mode   (alu_mode),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_flags  (out_flags)
    );

    // ALU stub
    logic [128:0] sum;
    assign sum        = {1'b0, alu_op1} + {1'b0, alu_op2};
    assign alu_result = sum[127:0];
    assign alu_flags  = {sum[128], (sum[127:0] == 128'd0), 1'b0, sum[127]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives nbeats beats; beat 0 carries sel0/mode, later beats sel_rest/~mode.
    // Returns at the negedge following the last transfer.
    task automatic send_frame(input logic [127:0] op1, input logic [127:0] op2,
                              input logic [2:0] sel0, input logic [2:0] sel_rest,
                              input logic mode, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            if (i < 4) in_data = op1[i*32 +: 32];
            else       in_data = op2[(i-4)*32 +: 32];
            in_opsel = (i == 0) ? sel0 : sel_rest;
            in_mode  = (i == 0) ? mode : ~mode;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL in_ready_beat%0d: got %b want 1", i, in_ready);
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Called at the negedge of the EXEC cycle; out beats follow.
    task automatic recv_frame(input logic [127:0] exp_res, input logic [3:0] exp_flags,
                              input int stall_beat, input int stall_n);
        logic [31:0] exp_word;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            exp_word = exp_res[b*32 +: 32];
            if (b == stall_beat) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    n_cmp++;
                    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_word ||
                        out_last !== (b == 3) || out_flags !== exp_flags) begin
                        n_fail++;
                        $display("FAIL stall_b%0d_c%0d: got v=%b r=%b d=%h l=%b f=%b want v=1 r=0 d=%h l=%b f=%b",
                                 b, s, out_valid, in_ready, out_data, out_last, out_flags,
                                 exp_word, (b == 3), exp_flags);
                    end
                    @(negedge clk);
                end
            end
            out_ready = 1'b1;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL out_valid_b%0d: got v=%b r=%b want v=1 r=0", b, out_valid, in_ready);
            end
            n_cmp++;
            if (out_data !== exp_word) begin
                n_fail++;
                $display("FAIL out_data_b%0d: got %h want %h", b, out_data, exp_word);
            end
            n_cmp++;
            if (out_last !== (b == 3)) begin
                n_fail++;
                $display("FAIL out_last_b%0d: got %b want %b", b, out_last, (b == 3));
            end
            n_cmp++;
            if (out_flags !== exp_flags) begin
                n_fail++;
                $display("FAIL out_flags_b%0d: got %b want %b", b, out_flags, exp_flags);
            end
            @(posedge clk);
        end
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_collect: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
    endtask

    // Called at the negedge of the EXEC cycle.
    task automatic check_exec(input logic [127:0] op1, input logic [127:0] op2,
                              input logic [2:0] sel, input logic mode);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL exec_handshake: got v=%b r=%b want v=0 r=0", out_valid, in_ready);
        end
        n_cmp++;
        if (alu_op1 !== op1 || alu_op2 !== op2) begin
            n_fail++;
            $display("FAIL exec_operands: got %h %h want %h %h", alu_op1, alu_op2, op1, op2);
        end
        n_cmp++;
        if (alu_opsel !== sel || alu_mode !== mode) begin
            n_fail++;
            $display("FAIL exec_sideband: got sel=%b mode=%b want sel=%b mode=%b",
                     alu_opsel, alu_mode, sel, mode);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            out_data !== 32'd0 || out_flags !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_stream: got r=%b v=%b l=%b d=%h f=%b want all 0",
                     in_ready, out_valid, out_last, out_data, out_flags);
        end
        n_cmp++;
        if (alu_op1 !== 128'd0 || alu_op2 !== 128'd0 || alu_opsel !== 3'd0 || alu_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_alu: got %h %h %b %b want all 0", alu_op1, alu_op2, alu_opsel, alu_mode);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic_add();
        send_frame(128'd1, 128'd2, 3'b000, 3'b000, 1'b0, 8);
        check_exec(128'd1, 128'd2, 3'b000, 1'b0);
        recv_frame(128'd3, 4'b0000, -1, 0);
    endtask

    task automatic test_carry_wrap();
        send_frame({128{1'b1}}, 128'd1, 3'b000, 3'b000, 1'b0, 8);
        check_exec({128{1'b1}}, 128'd1, 3'b000, 1'b0);
        recv_frame(128'd0, 4'b1100, -1, 0);
    endtask

    // Stall on beat 2, then a second frame immediately after (back-to-back).
    task automatic test_backpressure();
        send_frame(128'h0000_0004_0000_0003_0000_0002_0000_0001,
                   128'h8000_0000_0000_0000_0000_0000_0000_0000,
                   3'b001, 3'b001, 1'b1, 8);
        check_exec(128'h0000_0004_0000_0003_0000_0002_0000_0001,
                   128'h8000_0000_0000_0000_0000_0000_0000_0000, 3'b001, 1'b1);
        recv_frame(128'h8000_0004_0000_0003_0000_0002_0000_0001, 4'b0001, 2, 5);
        send_frame(128'h1_0000_0000, 128'h0000_0001_FFFF_FFFF, 3'b011, 3'b011, 1'b0, 8);
        check_exec(128'h1_0000_0000, 128'h0000_0001_FFFF_FFFF, 3'b011, 1'b0);
        recv_frame(128'h0000_0002_FFFF_FFFF, 4'b0000, -1, 0);
    endtask

    task automatic test_sideband();
        send_frame(128'd5, 128'd7, 3'b101, 3'b010, 1'b1, 8);
        check_exec(128'd5, 128'd7, 3'b101, 1'b1);
        recv_frame(128'd12, 4'b0000, -1, 0);
    endtask

    task automatic test_reset_mid_frame();
        send_frame({4{32'hAAAA_5555}}, 128'h1234_5678_0000_DEAD, 3'b111, 3'b000, 1'b1, 6);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (alu_op1 !== 128'd0 || alu_op2 !== 128'd0 || alu_opsel !== 3'd0 || alu_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_alu: got %h %h %b %b want all 0", alu_op1, alu_op2, alu_opsel, alu_mode);
        end
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_stream: got r=%b v=%b l=%b d=%h want all 0",
                     in_ready, out_valid, out_last, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL midreset_idle_c%0d: got v=%b r=%b want v=0 r=1", c, out_valid, in_ready);
            end
        end
        send_frame(128'h1_0000_0000, 128'd2, 3'b000, 3'b000, 1'b0, 8);
        check_exec(128'h1_0000_0000, 128'd2, 3'b000, 1'b0);
        recv_frame(128'h1_0000_0002, 4'b0000, -1, 0);
    endtask

`ifdef ALU128_SEQ_STICKY_EN
    task automatic test_sticky();
        send_frame({128{1'b1}}, 128'd1, 3'b000, 3'b000, 1'b0, 8);
        recv_frame(128'd0, 4'b1100, -1, 0);
        send_frame(128'd1, 128'd2, 3'b000, 3'b000, 1'b0, 8);
        recv_frame(128'd3, 4'b0000, -1, 0);
        n_cmp++;
        if (sticky_flags !== 2'b10) begin
            n_fail++;
            $display("FAIL sticky_hold: got %b want 10", sticky_flags);
        end
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        n_cmp++;
        if (sticky_flags !== 2'b00) begin
            n_fail++;
            $display("FAIL sticky_clear: got %b want 00", sticky_flags);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_opsel  = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
`ifdef ALU128_SEQ_STICKY_EN
        sticky_clr = 1'b0;
`endif
        test_reset();
        test_basic_add();
        test_carry_wrap();
        test_backpressure();
        test_sideband();
        test_reset_mid_frame();
`ifdef ALU128_SEQ_STICKY_EN
        test_sticky();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
